data_count_pipe: RTL and testbench
==================================

# data_count_pipe

Parametrised multi-channel data staging block: arbitrates NUM_CH valid/ready input streams round-robin into one registered output stream through a 2-entry skid buffer, and keeps a per-channel accepted-beat counter with selectable wrap/saturate behaviour. It sits between producer logic and a single downstream consumer. It generalises the single-channel enable/ready/data_in → output_data path with a sample counter to N channels, with proper backpressure and a counter mode.

## Interface
- DATA_W, 8, data width per channel
- NUM_CH, 2, number of input channels (≥1)
- CNT_W, 16, per-channel beat-counter width
- SAT, 0, counter mode: 0 = wrap at 2^CNT_W, 1 = saturate at all-ones
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- enable  input  1  global accept enable; low blocks new input beats
- in_valid  input  NUM_CH  per-channel beat valid
- in_ready  output  NUM_CH  per-channel accept (combinational)
- in_data  input  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- out_valid  output  1  output beat valid (registered)
- out_ready  input  1  downstream accept
- out_data  output  DATA_W  output beat data (registered)
- out_ch  output  max(1,$clog2(NUM_CH))  source channel of output beat
- cnt_clear  input  1  synchronous clear of all counters
- cnt  output  NUM_CH*CNT_W  channel c accepted-beat count at [c*CNT_W +: CNT_W]

## Operation
- Accept on channel c: in_valid[c] && in_ready[c].
- in_ready[c] = !reset && enable && (skid entry empty) && (grant == c); at most one bit high per cycle.
- Grant: first channel with in_valid set, searching from rr_ptr upward modulo NUM_CH; no grant if no in_valid.
- rr_ptr advances to (granted+1) mod NUM_CH only on an accept; unchanged otherwise (including enable low or buffer full).
- Skid buffer: output register + one skid entry, each holding {ch, data}.
  - Accept with output empty, or output being popped (out_valid && out_ready) and skid empty: beat goes to output register.
  - Accept while output held (out_valid && !out_ready): beat goes to skid entry.
  - On pop with skid full: skid moves to output register, skid becomes empty; in_ready stays low that cycle.
- Held output: out_data/out_ch stable while out_valid && !out_ready.
- Ordering: output order equals accept order.
- enable low: no accepts; buffered beats still drain.
- Counters: cnt[c] increments by 1 on an accept on channel c.
  - SAT=0: all-ones + 1 wraps to 0. SAT=1: holds at all-ones.
  - cnt_clear takes precedence: all counters go to 0, a same-cycle accept is not counted (beat still passes downstream).
- Reset (mid-operation included): buffered beats discarded, nothing drained.

## Timing
- Reset values: out_valid 0, out_data 0, out_ch 0, all cnt 0, rr_ptr 0, skid empty; in_ready all 0 while reset high.
- Latency: accept in cycle N → out_valid/out_data in cycle N+1.
- Throughput: 1 beat/cycle with out_ready held high.
- in_ready depends only on registered state, enable, reset and in_valid; no combinational path from out_ready.
- Counter visible on cnt one cycle after the accepting edge.

## Structure
- Package data_count_pkg: CH_W localparam function (max(1,$clog2(n))), entry struct typedef {ch, data} parameterised via widths, counter mode constants CNT_WRAP=0 / CNT_SAT=1.
- Sub-module skid_buffer (2-entry, valid/ready, WIDTH parameter) instantiated once for the {ch, data} entry. Arbiter and counters stay in the top module.

## Test plan
- Reset: reset high 3 cycles with all in_valid=1 → in_ready=0, out_valid=0, cnt all 0. First accept is ch0 after release.
- Round-robin: NUM_CH=4, all valid, enable=1, out_ready=1, data = 0x10+c → outputs ch 0,1,2,3,0… one per cycle, data 0x10,0x11,0x12,0x13.
- Backpressure: out_ready=0 for 5 cycles, ch0 streaming 0xA1,0xA2,0xA3 → exactly two accepts (0xA1 in output, 0xA2 in skid), in_ready low after. Release → 0xA1, 0xA2, 0xA3 in order, none lost or duplicated.
- Counter modes: CNT_W=4, 17 beats on ch1 → SAT=0 cnt[1]=1, SAT=1 cnt[1]=15.
- Clear collision: cnt_clear with ch0 accept same cycle, cnt[0]=5 before → cnt[0]=0 next cycle, beat still appears on out_data.
- Enable/reset mid-stream: enable=0 with 2 beats buffered → both drain, no accepts. Reset with out_valid=1 → out_valid=0 next cycle, rr_ptr=0.

Source files
------------

// File: rtl/data_count_pkg.sv
// rtl/data_count_pkg.sv - shared constants and helpers for data_count_pipe
package data_count_pkg;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    // A single channel still needs a 1-bit channel field.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - 2-entry valid/ready skid buffer with a registered output
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             pop;
    logic             push;

    // Ready comes only from the skid flag, so there is no path from m_tready.
    assign s_tready = !skid_valid_q;
    assign pop      = out_valid_q && m_tready;
    assign push     = s_tvalid && !skid_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (skid_valid_q) begin
            if (pop) begin
                out_data_q   <= skid_data_q;
                skid_valid_q <= 1'b0;
            end
        end else if (push) begin
            if (!out_valid_q || pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= s_tdata;
            end else begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= s_tdata;
            end
        end else if (pop) begin
            out_valid_q <= 1'b0;
        end
    end

    assign m_tvalid = out_valid_q;
    assign m_tdata  = out_data_q;

endmodule

// File: rtl/data_count_pipe.sv
// rtl/data_count_pipe.sv - round-robin N-channel stream merge with per-channel beat counters
module data_count_pipe
    import data_count_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter bit SAT    = CNT_WRAP
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_CH-1:0]             in_valid,
    output logic [NUM_CH-1:0]             in_ready,
    input  logic [NUM_CH*DATA_W-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [ch_width(NUM_CH)-1:0]   out_ch,
    input  logic                          cnt_clear,
    output logic [NUM_CH*CNT_W-1:0]       cnt
);

    localparam int CH_W = ch_width(NUM_CH);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  grant_idx;
    logic [CH_W-1:0]  cand;
    logic             grant_valid;
    logic             skid_ready;
    logic             accept;
    entry_t           in_entry;
    entry_t           out_entry;
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // First requesting channel at or above rr_ptr, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!grant_valid && in_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept = !reset && enable && skid_ready && grant_valid;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ready
        assign in_ready[c] = accept && (grant_idx == CH_W'(c));
    end

    always_comb begin
        in_entry.ch   = grant_idx;
        in_entry.data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_idx == CH_W'(c)) begin
                in_entry.data = in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= CH_W'((int'(grant_idx) + 1) % NUM_CH);
        end
    end

    skid_buffer #(
        .WIDTH ($bits(entry_t))
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .s_tvalid (accept),
        .s_tready (skid_ready),
        .s_tdata  (in_entry),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .m_tdata  (out_entry)
    );

    assign out_data = out_entry.data;
    assign out_ch   = out_entry.ch;

    // Clear wins over a same-cycle accept; the beat itself still goes downstream.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset || cnt_clear) begin
                cnt_q[c] <= '0;
            end else if (accept && (grant_idx == CH_W'(c))) begin
                if (!((SAT == CNT_SAT) && (&cnt_q[c]))) begin
                    cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
        assign cnt[c*CNT_W +: CNT_W] = cnt_q[c];
    end

endmodule

// File: tb/tb_data_count_pipe.sv
// tb/tb_data_count_pipe.sv - directed scoreboard bench for data_count_pipe
module tb_data_count_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        cnt_clear;

    logic [3:0]  in_ready,  s_in_ready;
    logic        out_valid, s_out_valid;
    logic [7:0]  out_data,  s_out_data;
    logic [1:0]  out_ch,    s_out_ch;
    logic [15:0] cnt_w,     cnt_s;

    int checks = 0;
    int errors = 0;
    int ew[4];
    int es[4];
    logic [9:0] sb[$];
    logic [9:0] e;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_ch;

    always #5 clk = ~clk;

    data_count_pipe #(.DATA_W(8), .NUM_CH(4), .CNT_W(4), .SAT(1'b0)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .cnt_clear(cnt_clear), .cnt(cnt_w)
    );

    data_count_pipe #(.DATA_W(8), .NUM_CH(4), .CNT_W(4), .SAT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_ch(s_out_ch), .cnt_clear(cnt_clear), .cnt(cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready/counters at negedge, record expected beats, update the count model.
    task automatic step(input logic [3:0] exp_rdy);
        logic [3:0] acc;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("in_ready_sat", 32'(s_in_ready), 32'(exp_rdy));
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("cnt_wrap[%0d]", c), 32'(cnt_w[c*4 +: 4]), 32'(ew[c]));
            chk($sformatf("cnt_sat[%0d]", c), 32'(cnt_s[c*4 +: 4]), 32'(es[c]));
        end
        acc = exp_rdy & in_valid;
        for (int c = 0; c < 4; c++) begin
            if (acc[c]) sb.push_back({2'(c), in_data[c*8 +: 8]});
        end
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            if (reset || cnt_clear) begin
                ew[c] = 0;
                es[c] = 0;
            end else if (acc[c]) begin
                ew[c] = (ew[c] + 1) % 16;
                if (es[c] < 15) es[c] = es[c] + 1;
            end
        end
        if (reset) sb.delete();
        #2;
    endtask

    always @(negedge clk) begin
        if (prev_hold && out_valid) begin
            chk("held_data", 32'(out_data), 32'(prev_data));
            chk("held_ch", 32'(out_ch), 32'(prev_ch));
        end
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_ch", 32'(out_ch), 32'(e[9:8]));
                chk("out_data", 32'(out_data), 32'(e[7:0]));
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_ch   = out_ch;
    end

    initial begin
        for (int c = 0; c < 4; c++) begin
            ew[c] = 0;
            es[c] = 0;
        end
        reset     = 1'b1;
        enable    = 1'b1;
        in_valid  = 4'hF;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) step(4'b0000);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_ch", 32'(out_ch), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) step(4'(1 << (i % 4)));
        in_valid = 4'b0000;
        step(4'b0000);

        in_valid  = 4'b0001;
        out_ready = 1'b0;
        in_data[7:0] = 8'hA1;
        step(4'b0001);
        in_data[7:0] = 8'hA2;
        step(4'b0001);
        in_data[7:0] = 8'hA3;
        for (int i = 0; i < 3; i++) step(4'b0000);
        out_ready = 1'b1;
        step(4'b0000);
        step(4'b0001);
        in_valid = 4'b0000;
        step(4'b0000);

        in_valid     = 4'b0001;
        in_data[7:0] = 8'h5C;
        cnt_clear    = 1'b1;
        step(4'b0001);
        cnt_clear = 1'b0;
        in_valid  = 4'b0000;
        step(4'b0000);
        chk("clear_collision_cnt0", 32'(cnt_w[3:0]), 32'd0);

        cnt_clear = 1'b1;
        step(4'b0000);
        cnt_clear = 1'b0;
        in_valid  = 4'b0010;
        for (int i = 0; i < 17; i++) begin
            in_data[15:8] = 8'(8'h60 + i);
            step(4'b0010);
        end
        in_valid = 4'b0000;
        step(4'b0000);
        chk("wrap_cnt1", 32'(cnt_w[7:4]), 32'd1);
        chk("sat_cnt1", 32'(cnt_s[7:4]), 32'd15);

        out_ready    = 1'b0;
        in_valid     = 4'b0001;
        in_data[7:0] = 8'h71;
        step(4'b0001);
        in_data[7:0] = 8'h72;
        step(4'b0001);
        enable   = 1'b0;
        in_valid = 4'b0101;
        step(4'b0000);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(4'b0000);
        chk("enable_low_drained", 32'(out_valid), 32'd0);

        enable        = 1'b1;
        out_ready     = 1'b0;
        in_valid      = 4'b0010;
        in_data[15:8] = 8'h81;
        step(4'b0010);
        reset    = 1'b1;
        in_valid = 4'hF;
        step(4'b0000);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_out_data", 32'(out_data), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        step(4'b0001);
        in_valid = 4'b0000;
        step(4'b0000);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
